// File: rtl/frame_window_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_window_ctrl_pkg
// Purpose  : Shared constants for the acoustic window controller: FSM state
//            encodings, default window geometry and a state decode helper.
// Revision : 1.0  initial release
// ============================================================================
package frame_window_ctrl_pkg;

  // Controller state encodings (3-bit)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // Default window geometry
  localparam int c_NUM_FRAMES_DEF  = 50;
  localparam int c_TIMEOUT_CYC_DEF = 100000;

  // True in the states where framing is enabled and frames are flowing
  function automatic logic is_active(input logic [2:0] st);
    return (st == ST_RUN) || (st == ST_DRAIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_window_ctrl_if
// Purpose  : Control/status bundle between the wake controller, the framing
//            block and the window controller.
// Revision : 1.0  initial release
// ============================================================================
interface frame_window_ctrl_if #(
  parameter int FIDX_BW = 6
);
  logic               start_i;
  logic               stop_i;
  logic               continuous_i;
  logic               frame_last_i;
  logic               done_ack_i;
  logic               framing_en_o;
  logic [FIDX_BW-1:0] frame_idx_o;
  logic               first_frame_o;
  logic               window_done_o;
  logic               error_o;
  logic               busy_o;

  // Side that drives commands and observes status
  modport master (
    output start_i, stop_i, continuous_i, frame_last_i, done_ack_i,
    input  framing_en_o, frame_idx_o, first_frame_o, window_done_o,
           error_o, busy_o
  );

  // The window controller itself
  modport slave (
    input  start_i, stop_i, continuous_i, frame_last_i, done_ack_i,
    output framing_en_o, frame_idx_o, first_frame_o, window_done_o,
           error_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/frame_window_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : frame_watchdog
// Purpose  : Saturating cycle counter that flags a stalled frame stream.
//            Clear has priority over enable; expire is high while the count
//            sits at TIMEOUT_CYC-1.
// Revision : 1.0  initial release
// ============================================================================
module frame_watchdog
  import frame_window_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF,
  parameter int TO_BW       = $clog2(TIMEOUT_CYC + 1)
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_expire
);

  localparam logic [TO_BW-1:0] c_LAST = TO_BW'(TIMEOUT_CYC - 1);

  logic [TO_BW-1:0] r_count;

  // Count enabled cycles, holding at the expiry value until cleared
  always_ff @(posedge clk_i) begin
    if (rst_i || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != c_LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/frame_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_window_ctrl
// Purpose  : Sequences the framing block through one analysis window: gates
//            its enable, counts frames from the last-element strobe, reports
//            window completion or a stalled stream, and supports stop/drain
//            and continuous windows.
// Revision : 1.0  initial release
// ============================================================================
module frame_window_ctrl
  import frame_window_ctrl_pkg::*;
#(
  parameter int NUM_FRAMES  = c_NUM_FRAMES_DEF,
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF,
  parameter int FIDX_BW     = $clog2(NUM_FRAMES),
  parameter int TO_BW       = $clog2(TIMEOUT_CYC + 1)
) (
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  frame_window_ctrl_if.slave  bus
);

  localparam logic [FIDX_BW-1:0] c_LAST_IDX = FIDX_BW'(NUM_FRAMES - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [FIDX_BW-1:0] r_idx;
  logic [FIDX_BW-1:0] w_idx_nxt;
  logic               r_stop_hold;
  logic               w_stop_hold_nxt;

  logic               w_active;
  logic               w_strobe;
  logic               w_last_idx;
  logic               w_expire;
  logic               w_wd_clr;

  logic               w_framing_en;
  logic               w_first_frame;
  logic               w_window_done;
  logic               w_error;
  logic               w_busy;

  // Strobes are only meaningful while framing is enabled
  assign w_active   = is_active(r_state);
  assign w_strobe   = w_active & bus.frame_last_i;
  assign w_last_idx = (r_idx == c_LAST_IDX);

  // Held at zero whenever framing is off, so every entry to RUN starts fresh;
  // every frame boundary restarts the stall timer.
  assign w_wd_clr = ~w_active | w_strobe;

  frame_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_BW       (TO_BW)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clr    (w_wd_clr),
    .i_en     (w_active),
    .o_expire (w_expire)
  );

  // State, frame index and sticky-stop registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_stop_hold <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_stop_hold <= w_stop_hold_nxt;
    end
  end

  // Next-state, next-index and sticky-stop decisions
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_stop_hold_nxt = r_stop_hold;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = '0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (w_strobe) begin
          // Strobe is counted first; a completed window always reports
          if (w_last_idx) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
            if ((r_state == ST_DRAIN) || bus.stop_i) begin
              w_state_nxt = ST_IDLE;
            end
          end
        end else if (w_expire) begin
          // A stall outranks a stop request arriving in the same cycle
          w_state_nxt = ST_ERR;
        end else if ((r_state == ST_RUN) && bus.stop_i) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (bus.done_ack_i) begin
          w_stop_hold_nxt = 1'b0;
          if (bus.continuous_i && !r_stop_hold && !bus.stop_i) begin
            w_state_nxt = ST_RUN;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (bus.stop_i) begin
          w_stop_hold_nxt = 1'b1;
        end
      end
      ST_ERR: begin
        // Index stays frozen for debug until acknowledged
        if (bus.done_ack_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_idx_nxt       = '0;
        w_stop_hold_nxt = 1'b0;
      end
    endcase
  end

  // Outputs decoded purely from registered state
  always_comb begin
    w_framing_en  = w_active;
    w_first_frame = w_active & (r_idx == '0);
    w_window_done = (r_state == ST_HOLD);
    w_error       = (r_state == ST_ERR);
    w_busy        = (r_state != ST_IDLE);
  end

  assign bus.framing_en_o  = w_framing_en;
  assign bus.frame_idx_o   = r_idx;
  assign bus.first_frame_o = w_first_frame;
  assign bus.window_done_o = w_window_done;
  assign bus.error_o       = w_error;
  assign bus.busy_o        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_frame_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_window_ctrl
// Purpose  : Self-checking bench for frame_window_ctrl with NUM_FRAMES=4 and
//            TIMEOUT_CYC=20, using a behavioural window model and directed
//            scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_frame_window_ctrl;

  localparam int NF = 4;
  localparam int TO = 20;
  localparam int FB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  frame_window_ctrl_if #(.FIDX_BW(FB)) bus ();

  frame_window_ctrl #(
    .NUM_FRAMES  (NF),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: framing on/off, draining, window complete, error,
  // frames counted and cycles since the last frame boundary.
  bit m_active   = 1'b0;
  bit m_draining = 1'b0;
  bit m_done     = 1'b0;
  bit m_err      = 1'b0;
  bit m_stopreq  = 1'b0;
  int m_idx      = 0;
  int m_quiet    = 0;

  function automatic void check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_step(input bit st, input bit sp, input bit fl,
                            input bit ack, input bit cont, input bit rs);
    if (rs) begin
      m_active = 0; m_draining = 0; m_done = 0; m_err = 0;
      m_stopreq = 0; m_idx = 0; m_quiet = 0;
    end else if (m_active) begin
      if (fl) begin
        m_quiet = 0;
        if (m_idx == NF - 1) begin
          m_active = 0; m_draining = 0; m_done = 1;
        end else begin
          m_idx = m_idx + 1;
          if (m_draining || sp) begin
            m_active = 0; m_draining = 0;
          end
        end
      end else if (m_quiet == TO - 1) begin
        m_active = 0; m_draining = 0; m_err = 1;
      end else begin
        m_quiet = m_quiet + 1;
        if (sp) m_draining = 1;
      end
    end else if (m_done) begin
      if (sp) m_stopreq = 1;
      if (ack) begin
        m_done = 0;
        if (cont && !m_stopreq) begin
          m_active = 1; m_idx = 0; m_quiet = 0;
        end
        m_stopreq = 0;
      end
    end else if (m_err) begin
      if (ack) m_err = 0;
    end else if (st) begin
      m_active = 1; m_idx = 0; m_quiet = 0;
    end
  endtask

  // One clock with the given inputs; pulses drop 1 time unit after the edge
  task automatic step(input bit st, input bit sp, input bit fl,
                      input bit ack, input bit cont, input bit rs);
    bus.start_i      = st;
    bus.stop_i       = sp;
    bus.frame_last_i = fl;
    bus.done_ack_i   = ack;
    bus.continuous_i = cont;
    rst              = rs;
    @(posedge clk);
    model_step(st, sp, fl, ack, cont, rs);
    #1;
    bus.start_i      = 1'b0;
    bus.stop_i       = 1'b0;
    bus.frame_last_i = 1'b0;
    bus.done_ack_i   = 1'b0;
    bus.continuous_i = 1'b0;
    rst              = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic strobe_after(input int gap);
    idle(gap);
    step(0, 0, 1, 0, 0, 0);
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("framing_en", int'(bus.framing_en_o), int'(m_active));
      check("frame_idx", int'(bus.frame_idx_o), m_idx);
      check("first_frame", int'(bus.first_frame_o), int'(m_active && m_idx == 0));
      check("window_done", int'(bus.window_done_o), int'(m_done));
      check("error", int'(bus.error_o), int'(m_err));
      check("busy", int'(bus.busy_o), int'(m_active || m_done || m_err));
    end
  end

  initial begin
    bus.start_i      = 1'b0;
    bus.stop_i       = 1'b0;
    bus.frame_last_i = 1'b0;
    bus.done_ack_i   = 1'b0;
    bus.continuous_i = 1'b0;

    // Reset state
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_en", int'(bus.framing_en_o), 0);
    check("rst_idx", int'(bus.frame_idx_o), 0);

    // Single window, then ignored strobes in HOLD and IDLE
    step(1, 0, 0, 0, 0, 0);
    check("start_en", int'(bus.framing_en_o), 1);
    check("start_first", int'(bus.first_frame_o), 1);
    check("model_start_idx", m_idx, 0);
    for (int k = 0; k < 3; k++) begin
      strobe_after(9);
      check("single_idx_step", int'(bus.frame_idx_o), k + 1);
    end
    strobe_after(9);
    check("single_done", int'(bus.window_done_o), 1);
    check("single_en_off", int'(bus.framing_en_o), 0);
    check("single_idx_held", int'(bus.frame_idx_o), 3);
    check("model_single_done", int'(m_done), 1);
    step(0, 0, 1, 0, 0, 0);
    check("hold_strobe_ignored", int'(bus.frame_idx_o), 3);
    step(0, 0, 0, 1, 0, 0);
    check("ack_idle_busy", int'(bus.busy_o), 0);
    step(0, 0, 1, 0, 0, 0);
    check("idle_strobe_ignored", int'(bus.busy_o), 0);

    // Continuous windows, start ignored in RUN
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) strobe_after(9);
    step(0, 0, 0, 1, 1, 0);
    check("cont_en", int'(bus.framing_en_o), 1);
    check("cont_idx", int'(bus.frame_idx_o), 0);
    strobe_after(3);
    step(1, 0, 0, 0, 0, 0);
    check("run_start_ignored", int'(bus.frame_idx_o), 1);
    for (int k = 0; k < 3; k++) strobe_after(9);
    check("cont_second_done", int'(bus.window_done_o), 1);
    // Stop while holding overrides continuous on ack
    step(0, 1, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 1, 0);
    check("hold_stop_idle", int'(bus.busy_o), 0);

    // Stop after the 2nd strobe drains until the 3rd
    step(1, 0, 0, 0, 0, 0);
    strobe_after(9);
    strobe_after(9);
    step(0, 1, 0, 0, 0, 0);
    check("drain_en", int'(bus.framing_en_o), 1);
    idle(5);
    strobe_after(2);
    check("drain_idle", int'(bus.busy_o), 0);
    check("drain_idx", int'(bus.frame_idx_o), 3);
    check("drain_no_done", int'(bus.window_done_o), 0);

    // Stop coincident with the 2nd strobe
    step(1, 0, 0, 0, 0, 0);
    strobe_after(9);
    idle(9);
    step(0, 1, 1, 0, 0, 0);
    check("stop_coinc_idle", int'(bus.busy_o), 0);
    check("stop_coinc_idx", int'(bus.frame_idx_o), 2);

    // Watchdog expiry after 20 strobe-less cycles
    step(1, 0, 0, 0, 0, 0);
    idle(19);
    check("wd_not_yet", int'(bus.error_o), 0);
    idle(1);
    check("wd_error", int'(bus.error_o), 1);
    check("wd_en_off", int'(bus.framing_en_o), 0);
    check("model_wd_error", int'(m_err), 1);
    step(0, 0, 0, 1, 0, 0);
    check("err_ack_idle", int'(bus.busy_o), 0);

    // Strobe exactly in the expiry cycle wins
    step(1, 0, 0, 0, 0, 0);
    strobe_after(19);
    check("wd_strobe_no_err", int'(bus.error_o), 0);
    check("wd_strobe_idx", int'(bus.frame_idx_o), 1);
    idle(15);
    check("wd_rearmed", int'(bus.error_o), 0);

    // Reset mid-window at frame index 2, then restart
    strobe_after(2);
    check("pre_rst_idx", int'(bus.frame_idx_o), 2);
    step(0, 0, 0, 0, 0, 1);
    check("mid_rst_busy", int'(bus.busy_o), 0);
    check("mid_rst_en", int'(bus.framing_en_o), 0);
    check("mid_rst_idx", int'(bus.frame_idx_o), 0);
    step(1, 0, 0, 0, 0, 0);
    check("restart_idx", int'(bus.frame_idx_o), 0);
    check("restart_first", int'(bus.first_frame_o), 1);
    step(0, 1, 0, 0, 0, 0);
    strobe_after(1);
    idle(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
